product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter COUNT, default 4, number of products summed per result; legal range 1..16.
REQ-002 Parameter ACC_W, default 12, accumulator and SUM width in bits; legal range 8..16.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
REQ-005 PROD  input  8  unsigned product from the upstream 4x4 array multiplier.
REQ-006 in_valid  input  1  PROD is valid this cycle.
REQ-007 in_ready  output  1  block accepts PROD this cycle.
REQ-008 clear  input  1  synchronous abort of the current accumulation.
REQ-009 SUM  output  ACC_W  accumulated result, valid while out_valid=1.
REQ-010 out_valid  output  1  SUM holds a completed result.
REQ-011 out_ready  input  1  downstream consumes SUM this cycle.
REQ-012 OVF  output  1  result wrapped modulo 2^ACC_W; qualified by out_valid.

Function
REQ-013 Two states: ACCUM and HOLD; reset state ACCUM.
REQ-014 Accept = in_valid & in_ready; in_ready shall be 1 in ACCUM, 0 in HOLD (combinational from state only, no dependence on in_valid).
REQ-015 On accept in ACCUM: acc <= acc + zero-extended PROD, modulo 2^ACC_W; cnt <= cnt + 1; if carry out of bit ACC_W-1, ovf flag sets (sticky until result consumed or cleared).
REQ-016 Accept that brings cnt to COUNT: state -> HOLD next edge; out_valid=1 in the cycle after that accept (latency 1 cycle from last accept).
REQ-017 In HOLD: SUM, OVF stable; PROD/in_valid ignored; out_valid stays 1 until out_ready=1.
REQ-018 In HOLD with out_ready=1: acc, cnt, ovf <= 0; state -> ACCUM; in_ready=1 next cycle (no same-cycle pass-through of new input).
REQ-019 out_ready while in ACCUM has no effect.
REQ-020 SUM shall equal acc in all states; OVF equals ovf flag; outside HOLD they are don't-care to downstream but still driven.
REQ-021 clear=1 (any state): acc, cnt, ovf <= 0, state -> ACCUM; clear beats a simultaneous accept (input dropped) and a simultaneous out_ready (result discarded, no handshake counted).
REQ-022 in_valid=0 cycles in ACCUM leave acc and cnt unchanged (gaps allowed between products).
REQ-023 PROD=0 accepts count toward COUNT like any other value.
REQ-024 COUNT=1: every accept goes straight to HOLD.

Reset
REQ-025 rst_n=0 asynchronously forces acc=0, cnt=0, ovf=0, state=ACCUM: SUM=0, OVF=0, out_valid=0, in_ready=1, independent of clk.
REQ-026 Reset mid-accumulation or in HOLD discards partial sum and pending result; first accept after release starts a new group with cnt=0.
REQ-027 Deassertion of rst_n is synchronised externally; block takes no action on the release edge other than resuming.

Verification
REQ-028 Defaults; four accepts of PROD=225 (15x15) back-to-back -> one cycle later SUM=900, OVF=0, out_valid=1, in_ready=0.
REQ-029 Result held with out_ready=0 for 5 cycles while in_valid=1, PROD=99 -> SUM stays 900, no input accepted; out_ready=1 -> next cycle out_valid=0, in_ready=1, SUM=0.
REQ-030 COUNT=16, sixteen PROD=225 with random in_valid gaps -> SUM=3600, OVF=0; products 1,2,3,4 (COUNT=4) -> SUM=10.
REQ-031 ACC_W=8, COUNT=2, PROD=225 then 225 -> SUM=194, OVF=1; next group 1,1 -> SUM=2, OVF=0.
REQ-032 Two products accepted (100,50), then clear=1 together with in_valid=1 -> SUM=0, cnt=0, that input dropped; next four PROD=10 -> SUM=40.
REQ-033 rst_n pulsed low between clock edges while in HOLD with SUM=900 -> out_valid=0, SUM=0, in_ready=1 immediately, before next clk edge.

Source files
------------

// File: rtl/product_accumulator_if.sv
// ---------------------------------------------------------------------------
// product_accumulator_if
// Purpose : bundles the product input stream, the abort control and the
//           result output stream of product_accumulator.
// Signals : PROD[7:0]      unsigned product from the upstream multiplier
//           in_valid       PROD is valid this cycle
//           in_ready       accumulator accepts PROD this cycle
//           clear          synchronous abort of the current accumulation
//           SUM[ACC_W-1:0] accumulated result, valid while out_valid=1
//           out_valid      SUM holds a completed result
//           out_ready      downstream consumes SUM this cycle
//           OVF            result wrapped modulo 2^ACC_W (qualified by out_valid)
// Modports: master - the side that supplies products and consumes results
//           slave  - the accumulator itself
// ---------------------------------------------------------------------------
interface product_accumulator_if #(
  parameter int ACC_W = 12
);
  logic [7:0]       PROD;
  logic             in_valid;
  logic             in_ready;
  logic             clear;
  logic [ACC_W-1:0] SUM;
  logic             out_valid;
  logic             out_ready;
  logic             OVF;

  modport master (
    output PROD, in_valid, clear, out_ready,
    input  in_ready, SUM, out_valid, OVF
  );

  modport slave (
    input  PROD, in_valid, clear, out_ready,
    output in_ready, SUM, out_valid, OVF
  );
endinterface

// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
// Purpose : sums COUNT unsigned 8-bit products into an ACC_W-bit result
//           (modulo 2^ACC_W, with a sticky wrap flag), then holds the result
//           until the downstream consumer takes it.
// Params  : COUNT  products summed per result (1..16)
//           ACC_W  accumulator / SUM width in bits (8..16)
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           bus    product_accumulator_if.slave (PROD/in_valid/in_ready,
//                  clear, SUM/OVF/out_valid/out_ready)
// ---------------------------------------------------------------------------
module product_accumulator #(
  parameter int COUNT = 4,
  parameter int ACC_W = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  product_accumulator_if.slave  bus
);

  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q,   acc_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               ovf_q,   ovf_d;

  logic               accept;
  logic [ACC_W:0]     sum_ext;

  // Zero-extends the product and adds it to the accumulator; the extra top
  // bit of the result is the carry out of bit ACC_W-1.
  function automatic logic [ACC_W:0] add_wrap(
    input logic [ACC_W-1:0] acc,
    input logic [7:0]       prod
  );
    logic [ACC_W:0] a_ext;
    logic [ACC_W:0] p_ext;
    a_ext    = {1'b0, acc};
    p_ext    = {{(ACC_W + 1 - 8){1'b0}}, prod};
    add_wrap = a_ext + p_ext;
  endfunction

  // ---- next-state / datapath ----
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    accept  = bus.in_valid && (state_q == ACCUM);
    sum_ext = add_wrap(acc_q, bus.PROD);

    if (bus.clear) begin
      // Abort wins over a simultaneous accept or result handshake.
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_d = sum_ext[ACC_W-1:0];
            ovf_d = ovf_q | sum_ext[ACC_W];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(COUNT - 1)) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          // Result consumed: restart empty; new input is taken next cycle.
          if (bus.out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = ACCUM;
        end
      endcase
    end
  end

  // ---- state registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // ---- outputs (registered state only) ----
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.SUM       = acc_q;
  assign bus.OVF       = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  product_accumulator_if #(.ACC_W(12)) if_a ();
  product_accumulator_if #(.ACC_W(12)) if_b ();
  product_accumulator_if #(.ACC_W(8))  if_c ();
  product_accumulator_if #(.ACC_W(8))  if_d ();

  product_accumulator #(.COUNT(4),  .ACC_W(12)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  product_accumulator #(.COUNT(16), .ACC_W(12)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  product_accumulator #(.COUNT(2),  .ACC_W(8))  u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));
  product_accumulator #(.COUNT(1),  .ACC_W(8))  u_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] p);
    if_a.PROD = p; if_a.in_valid = 1'b1; tick(); if_a.in_valid = 1'b0;
  endtask
  task automatic push_c(input logic [7:0] p);
    if_c.PROD = p; if_c.in_valid = 1'b1; tick(); if_c.in_valid = 1'b0;
  endtask

  task automatic consume_a();
    if_a.out_ready = 1'b1; tick(); if_a.out_ready = 1'b0;
  endtask
  task automatic consume_c();
    if_c.out_ready = 1'b1; tick(); if_c.out_ready = 1'b0;
  endtask

  initial begin
    if_a.PROD = '0; if_a.in_valid = 0; if_a.clear = 0; if_a.out_ready = 0;
    if_b.PROD = '0; if_b.in_valid = 0; if_b.clear = 0; if_b.out_ready = 0;
    if_c.PROD = '0; if_c.in_valid = 0; if_c.clear = 0; if_c.out_ready = 0;
    if_d.PROD = '0; if_d.in_valid = 0; if_d.clear = 0; if_d.out_ready = 0;

    // Reset state, observed before any clock edge.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_sum",       32'(if_a.SUM),  0);
    check_eq("rst_out_valid", 32'(if_a.out_valid), 0);
    check_eq("rst_in_ready",  32'(if_a.in_ready),  1);
    check_eq("rst_ovf",       32'(if_a.OVF),  0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // COUNT=1: a single accept completes a result.
    if_d.PROD = 8'd7; if_d.in_valid = 1'b1; tick(); if_d.in_valid = 1'b0;
    check_eq("c1_out_valid", 32'(if_d.out_valid), 1);
    check_eq("c1_sum",       32'(if_d.SUM), 7);
    check_eq("c1_in_ready",  32'(if_d.in_ready), 0);
    if_d.out_ready = 1'b1; tick(); if_d.out_ready = 1'b0;
    check_eq("c1_consumed", 32'(if_d.out_valid), 0);

    // ACC_W=8, COUNT=2: wrap sets OVF; next group clears it.
    push_c(8'd225);
    check_eq("w8_partial_valid", 32'(if_c.out_valid), 0);
    check_eq("w8_partial_sum",   32'(if_c.SUM), 225);
    push_c(8'd225);
    check_eq("w8_sum",   32'(if_c.SUM), 194);
    check_eq("w8_ovf",   32'(if_c.OVF), 1);
    check_eq("w8_valid", 32'(if_c.out_valid), 1);
    consume_c();
    check_eq("w8_ovf_cleared", 32'(if_c.OVF), 0);
    push_c(8'd1);
    push_c(8'd1);
    check_eq("w8_sum2",   32'(if_c.SUM), 2);
    check_eq("w8_ovf2",   32'(if_c.OVF), 0);
    check_eq("w8_valid2", 32'(if_c.out_valid), 1);
    consume_c();

    // COUNT=16 with random gaps; the bench counts its own accepts.
    acc_cnt = 0;
    if_b.PROD = 8'd225;
    for (int i = 0; i < 400 && !if_b.out_valid; i++) begin
      if_b.in_valid = 1'($urandom_range(0, 1));
      if (if_b.in_valid && if_b.in_ready) acc_cnt++;
      tick();
    end
    if_b.in_valid = 1'b0;
    check_eq("c16_valid",   32'(if_b.out_valid), 1);
    check_eq("c16_sum",     32'(if_b.SUM), 3600);
    check_eq("c16_ovf",     32'(if_b.OVF), 0);
    check_eq("c16_accepts", 32'(acc_cnt), 16);

    // Default config: four back-to-back 225s.
    for (int i = 0; i < 4; i++) begin
      push_a(8'd225);
      if (i < 3) check_eq("b2b_not_done", 32'(if_a.out_valid), 0);
    end
    check_eq("b2b_sum",      32'(if_a.SUM), 900);
    check_eq("b2b_ovf",      32'(if_a.OVF), 0);
    check_eq("b2b_valid",    32'(if_a.out_valid), 1);
    check_eq("b2b_in_ready", 32'(if_a.in_ready), 0);

    // Hold under back-pressure while inputs keep arriving.
    if_a.PROD = 8'd99; if_a.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("hold_sum",   32'(if_a.SUM), 900);
      check_eq("hold_valid", 32'(if_a.out_valid), 1);
    end
    if_a.out_ready = 1'b1;
    tick();
    if_a.out_ready = 1'b0; if_a.in_valid = 1'b0;
    check_eq("drain_valid",    32'(if_a.out_valid), 0);
    check_eq("drain_in_ready", 32'(if_a.in_ready), 1);
    check_eq("drain_sum",      32'(if_a.SUM), 0);

    // 1, gap (with stray out_ready), 2, 3, 4.
    push_a(8'd1);
    if_a.out_ready = 1'b1; tick(); if_a.out_ready = 1'b0;
    check_eq("gap_sum",   32'(if_a.SUM), 1);
    check_eq("gap_valid", 32'(if_a.out_valid), 0);
    push_a(8'd2); push_a(8'd3); push_a(8'd4);
    check_eq("seq_sum",   32'(if_a.SUM), 10);
    check_eq("seq_valid", 32'(if_a.out_valid), 1);
    consume_a();

    // Clear beats a simultaneous accept.
    push_a(8'd100); push_a(8'd50);
    check_eq("pre_clear_sum", 32'(if_a.SUM), 150);
    if_a.clear = 1'b1; if_a.PROD = 8'd77; if_a.in_valid = 1'b1;
    tick();
    if_a.clear = 1'b0; if_a.in_valid = 1'b0;
    check_eq("clear_sum",      32'(if_a.SUM), 0);
    check_eq("clear_in_ready", 32'(if_a.in_ready), 1);
    for (int i = 0; i < 4; i++) begin
      push_a(8'd10);
      if (i < 3) check_eq("post_clear_not_done", 32'(if_a.out_valid), 0);
    end
    check_eq("post_clear_sum",   32'(if_a.SUM), 40);
    check_eq("post_clear_valid", 32'(if_a.out_valid), 1);

    // Clear in HOLD beats out_ready.
    if_a.clear = 1'b1; if_a.out_ready = 1'b1;
    tick();
    if_a.clear = 1'b0; if_a.out_ready = 1'b0;
    check_eq("clear_hold_valid", 32'(if_a.out_valid), 0);
    check_eq("clear_hold_sum",   32'(if_a.SUM), 0);

    // Zero products still count.
    for (int i = 0; i < 4; i++) push_a(8'd0);
    check_eq("zero_valid", 32'(if_a.out_valid), 1);
    check_eq("zero_sum",   32'(if_a.SUM), 0);
    consume_a();

    // Asynchronous reset while holding 900.
    for (int i = 0; i < 4; i++) push_a(8'd225);
    check_eq("pre_rst_sum", 32'(if_a.SUM), 900);
    #3 rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid",    32'(if_a.out_valid), 0);
    check_eq("async_rst_sum",      32'(if_a.SUM), 0);
    check_eq("async_rst_in_ready", 32'(if_a.in_ready), 1);
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      push_a(8'd5);
      if (i < 3) check_eq("post_rst_not_done", 32'(if_a.out_valid), 0);
    end
    check_eq("post_rst_sum",   32'(if_a.SUM), 20);
    check_eq("post_rst_valid", 32'(if_a.out_valid), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
